pc_sequencer: RTL and testbench

- Parametrised program-counter and control-flow unit for the next-generation core.
- Owns the PC register and next-PC selection (sequential, branch, jump, jump-register).
- Adds features the single-cycle PC logic lacks: stall hold, latched interrupt request, supervisor-mode masking, exception/interrupt vectoring with an EPC value and write strobe, and a retired-instruction counter.
- Sits between the controller/ALU and instruction ROM. Its EPC output feeds the register-file Xp write path.

---
 rtl/pc_sequencer.sv | 95 +++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and control-flow unit: next-PC selection, stall hold, latched IRQ,
// supervisor masking, exception/interrupt vectoring with EPC, and a retired-instruction counter.
module pc_sequencer #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [ADDR_W-1:0]  IRQ_VEC  = 32'h80000004,
    parameter logic [ADDR_W-1:0]  EXC_VEC  = 32'h80000008,
    parameter int                 JT_W     = 26,
    parameter int                 CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        pcsrc,
    input  logic              branch_taken,
    input  logic [15:0]       imm16,
    input  logic [JT_W-1:0]   jt,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              illegal_op,
    input  logic              irq_in,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              supervisor,
    output logic [ADDR_W-1:0] epc,
    output logic              epc_we,
    output logic              irq_ack,
    output logic              irq_pending,
    output logic [CNT_W-1:0]  instr_count
);
    localparam int LOW_W = ADDR_W - 1;
    localparam int JX_W  = (JT_W + 2 > LOW_W) ? JT_W + 2 : LOW_W;

    logic              irq_prev;
    logic              irq_edge;
    logic              take_exc;
    logic              take_irq;
    logic [LOW_W-1:0]  br_off;
    logic [LOW_W-1:0]  br_low;
    logic [JX_W-1:0]   jt_wide;
    logic [ADDR_W-1:0] next_pc;

    // The supervisor bit sits outside all address arithmetic; only vectors and jr change it.
    assign supervisor = pc[ADDR_W-1];
    assign pc_plus4   = {pc[ADDR_W-1], pc[LOW_W-1:0] + LOW_W'(4)};

    assign irq_edge = irq_in & ~irq_prev;
    assign take_exc = ~stall & illegal_op & ~supervisor;
    assign take_irq = ~stall & irq_pending & ~supervisor & ~take_exc;

    assign epc_we  = take_exc | take_irq;
    assign irq_ack = take_irq;
    // Exceptions resume after the faulting op; interrupts re-execute the interrupted one.
    assign epc     = take_exc ? pc_plus4 : pc;

    assign br_off  = {{(LOW_W-18){imm16[15]}}, imm16, 2'b00};
    assign br_low  = pc_plus4[LOW_W-1:0] + br_off;
    assign jt_wide = JX_W'({jt, 2'b00});

    always_comb begin
        next_pc = pc_plus4;
        if (take_exc) begin
            next_pc = EXC_VEC;
        end else if (take_irq) begin
            next_pc = IRQ_VEC;
        end else begin
            case (pcsrc)
                3'b001: if (branch_taken) next_pc = {pc[ADDR_W-1], br_low};
                3'b010: next_pc = {pc[ADDR_W-1], jt_wide[LOW_W-1:0]};
                3'b011: next_pc = supervisor ? jr_target : {1'b0, jr_target[LOW_W-1:0]};
                default: next_pc = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            irq_prev    <= 1'b0;
            irq_pending <= 1'b0;
            instr_count <= '0;
        end else begin
            irq_prev <= irq_in;
            // A fresh edge wins over the clear so a request arriving during the take is not lost.
            if (irq_edge)
                irq_pending <= 1'b1;
            else if (take_irq)
                irq_pending <= 1'b0;
            if (!stall) begin
                pc <= next_pc;
                if (!(take_exc | take_irq))
                    instr_count <= instr_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, branches, jumps, traps, masking and stall.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  pcsrc;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] jt;
    logic [31:0] jr_target;
    logic        illegal_op;
    logic        irq_in;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        supervisor;
    logic [31:0] epc;
    logic        epc_we;
    logic        irq_ack;
    logic        irq_pending;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .pcsrc(pcsrc),
        .branch_taken(branch_taken), .imm16(imm16), .jt(jt), .jr_target(jr_target),
        .illegal_op(illegal_op), .irq_in(irq_in), .pc(pc), .pc_plus4(pc_plus4),
        .supervisor(supervisor), .epc(epc), .epc_we(epc_we), .irq_ack(irq_ack),
        .irq_pending(irq_pending), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".count"}, instr_count, exp_cnt);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; pcsrc = 3'b000; branch_taken = 1'b0;
        imm16 = 16'h0; jt = 26'h0; jr_target = 32'h0; illegal_op = 1'b0; irq_in = 1'b0;

        #2;
        check_state("reset", 32'h0, 32'h0);
        check("reset.pending", {31'b0, irq_pending}, 32'h0);
        check("reset.epc_we", {31'b0, epc_we}, 32'h0);
        check("reset.irq_ack", {31'b0, irq_ack}, 32'h0);
        #1 reset = 1'b1;

        for (int i = 0; i < 3; i++) step();
        check_state("seq3", 32'h0000000C, 32'd3);
        check("seq3.plus4", pc_plus4, 32'h00000010);
        check("seq3.super", {31'b0, supervisor}, 32'h0);

        reset = 1'b0;
        #1;
        check_state("midreset", 32'h0, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) step();
        check_state("seq4", 32'h00000010, 32'd4);

        pcsrc = 3'b001; imm16 = 16'hFFFE; branch_taken = 1'b1;
        step();
        check_state("br_taken", 32'h0000000C, 32'd5);
        pcsrc = 3'b000;
        step();
        pcsrc = 3'b001; branch_taken = 1'b0;
        step();
        check_state("br_not", 32'h00000014, 32'd7);

        pcsrc = 3'b010; jt = 26'h40;
        step();
        check_state("jmp_user", 32'h00000100, 32'd8);

        // irq edge captured while stalled so pc stays at 0x100
        pcsrc = 3'b000; stall = 1'b1; irq_in = 1'b1;
        step();
        check_state("irq_cap", 32'h00000100, 32'd8);
        check("irq_cap.pending", {31'b0, irq_pending}, 32'h1);

        stall = 1'b0; illegal_op = 1'b1;
        settle();
        check("exc.epc_we", {31'b0, epc_we}, 32'h1);
        check("exc.epc", epc, 32'h00000104);
        check("exc.irq_ack", {31'b0, irq_ack}, 32'h0);
        step();
        check_state("exc", 32'h80000008, 32'd8);
        check("exc.pending", {31'b0, irq_pending}, 32'h1);
        check("exc.super", {31'b0, supervisor}, 32'h1);

        irq_in = 1'b0;
        settle();
        check("mask.epc_we", {31'b0, epc_we}, 32'h0);
        check("mask.irq_ack", {31'b0, irq_ack}, 32'h0);
        step();
        check_state("mask", 32'h8000000C, 32'd9);
        illegal_op = 1'b0;

        pcsrc = 3'b011; jr_target = 32'h80000020;
        step();
        check_state("jr_super", 32'h80000020, 32'd10);
        pcsrc = 3'b010; jt = 26'h40;
        step();
        check_state("jmp_super", 32'h80000100, 32'd11);

        pcsrc = 3'b011; jr_target = 32'hFFFFFFFC;
        step();
        check_state("jr_top", 32'hFFFFFFFC, 32'd12);
        check("wrap.plus4", pc_plus4, 32'h80000000);
        pcsrc = 3'b000;
        step();
        check_state("wrap", 32'h80000000, 32'd13);
        check("wrap.pending", {31'b0, irq_pending}, 32'h1);

        pcsrc = 3'b011; jr_target = 32'h00000040;
        step();
        check_state("trap_ret", 32'h00000040, 32'd14);

        // pending irq taken on first user cycle, with a new edge in the same cycle
        pcsrc = 3'b000; irq_in = 1'b1;
        settle();
        check("irq.epc_we", {31'b0, epc_we}, 32'h1);
        check("irq.irq_ack", {31'b0, irq_ack}, 32'h1);
        check("irq.epc", epc, 32'h00000040);
        step();
        check_state("irq", 32'h80000004, 32'd14);
        check("irq.edge_keep", {31'b0, irq_pending}, 32'h1);

        pcsrc = 3'b011; jr_target = 32'h00000040;
        step();
        check_state("ret2", 32'h00000040, 32'd15);

        pcsrc = 3'b000; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            irq_in = (i == 0) ? 1'b0 : 1'b1;
            settle();
            check("stall.epc_we", {31'b0, epc_we}, 32'h0);
            check("stall.irq_ack", {31'b0, irq_ack}, 32'h0);
            step();
            check_state("stall", 32'h00000040, 32'd15);
            check("stall.pending", {31'b0, irq_pending}, 32'h1);
        end

        stall = 1'b0;
        settle();
        check("unstall.epc_we", {31'b0, epc_we}, 32'h1);
        check("unstall.irq_ack", {31'b0, irq_ack}, 32'h1);
        check("unstall.epc", epc, 32'h00000040);
        step();
        check_state("unstall", 32'h80000004, 32'd15);
        check("unstall.pending", {31'b0, irq_pending}, 32'h0);

        irq_in = 1'b0; pcsrc = 3'b100;
        step();
        check_state("reserved", 32'h80000008, 32'd16);

        stall = 1'b1; irq_in = 1'b1; pcsrc = 3'b000;
        step();
        check_state("stall_cap", 32'h80000008, 32'd16);
        check("stall_cap.pending", {31'b0, irq_pending}, 32'h1);

        stall = 1'b0; pcsrc = 3'b011; jr_target = 32'h00000040;
        step();
        check_state("ret3", 32'h00000040, 32'd17);
        pcsrc = 3'b000;
        settle();
        check("irq3.irq_ack", {31'b0, irq_ack}, 32'h1);
        check("irq3.epc", epc, 32'h00000040);
        step();
        check_state("irq3", 32'h80000004, 32'd17);
        check("irq3.pending", {31'b0, irq_pending}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
